// File: rtl/mips_pkg.sv
// Shared fetch-side types and default address constants for the PC sequencer.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    // Encoding order doubles as redirect priority: a larger value wins.
    typedef enum logic [1:0] {
        NONE,
        BRANCH,
        JUMP,
        EXC
    } redirect_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/pc_target_calc.sv
// Purpose: derive pc+4, branch target and jump target from pc and instruction fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module pc_target_calc (
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    output logic [31:0] pcplus4,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target
);

    logic [31:0] br_offset;

    always_comb begin
        pcplus4       = pc + 32'd4;
        br_offset     = {{14{instr[15]}}, instr[15:0], 2'b00};
        branch_target = pcplus4 + br_offset;
        jump_target   = {pcplus4[31:28], instr[25:0], 2'b00};
    end

endmodule

// File: rtl/pc_sequencer.sv
// Purpose: owns the fetch PC, advances/redirects it and flushes on redirect; PC_SEQ_EXC_EN adds exceptions.
// Latency: accepted redirect lands on pc one edge later, with flush high for that one cycle.
// Backpressure: stall or !imem_ready holds pc; a blocked redirect waits in HOLD (exc ignores both).
module pc_sequencer
    import mips_pkg::*;
#(
`ifdef PC_SEQ_EXC_EN
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
`endif
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [25:0] instr,
`ifdef PC_SEQ_EXC_EN
    input  logic        exc,
    output logic [31:0] epc,
`endif
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        flush
);

    state_t      state;
    redirect_t   pend_kind;
    logic [31:0] pend_target;

    redirect_t   req_kind;
    logic [31:0] req_target;
    redirect_t   sel_kind;
    logic [31:0] sel_target;

    logic [31:0] pcplus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        advance;

    pc_target_calc u_target_calc (
        .pc            (pc),
        .instr         (instr),
        .pcplus4       (pcplus4),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    assign advance = imem_ready && !stall;

    // Later assignments override earlier ones, giving exc > jump > pcsrc.
    always_comb begin
        req_kind   = NONE;
        req_target = pcplus4;
        if (pcsrc) begin
            req_kind   = BRANCH;
            req_target = branch_target;
        end
        if (jump) begin
            req_kind   = JUMP;
            req_target = jump_target;
        end
`ifdef PC_SEQ_EXC_EN
        if (exc) begin
            req_kind   = EXC;
            req_target = EXC_VECTOR;
        end
`endif
    end

    // pend_kind is always NONE in FETCH, so this merge is a pass-through there.
    always_comb begin
        sel_kind   = pend_kind;
        sel_target = pend_target;
        if (req_kind > pend_kind) begin
            sel_kind   = req_kind;
            sel_target = req_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            flush       <= 1'b0;
            pend_kind   <= NONE;
            pend_target <= '0;
`ifdef PC_SEQ_EXC_EN
            epc         <= '0;
`endif
        end else begin
            flush <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH, HOLD: begin
`ifdef PC_SEQ_EXC_EN
                    if (sel_kind == EXC) begin
                        pc        <= sel_target;
                        epc       <= pc;
                        flush     <= 1'b1;
                        pend_kind <= NONE;
                        state     <= FETCH;
                    end else
`endif
                    if (advance) begin
                        if (sel_kind != NONE) begin
                            pc    <= sel_target;
                            flush <= 1'b1;
                        end else begin
                            pc <= pcplus4;
                        end
                        pend_kind <= NONE;
                        state     <= FETCH;
                    end else if (sel_kind != NONE) begin
                        pend_kind   <= sel_kind;
                        pend_target <= sel_target;
                        state       <= HOLD;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; exception steps are included when PC_SEQ_EXC_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic        pcsrc;
    logic        jump;
    logic [25:0] instr;
    logic [31:0] pc;
    logic        imem_req;
    logic        flush;
`ifdef PC_SEQ_EXC_EN
    logic        exc;
    logic [31:0] epc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .imem_ready (imem_ready),
        .pcsrc      (pcsrc),
        .jump       (jump),
        .instr      (instr),
`ifdef PC_SEQ_EXC_EN
        .exc        (exc),
        .epc        (epc),
`endif
        .pc         (pc),
        .imem_req   (imem_req),
        .flush      (flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic goto_addr(input logic [31:0] a, input string tag);
        logic [31:0] t;
        t     = a >> 2;
        jump  = 1'b1;
        instr = t[25:0];
        tick();
        jump  = 1'b0;
        instr = '0;
        check({tag, "_pc"}, pc, a);
        check({tag, "_flush"}, {31'd0, flush}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        imem_ready = 1'b1;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        instr      = '0;
`ifdef PC_SEQ_EXC_EN
        exc        = 1'b0;
`endif
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
`ifdef PC_SEQ_EXC_EN
        check("rst_epc", epc, 32'h0);
`endif

        // Straight-line fetch after reset release.
        reset = 1'b0;
        tick();
        check("boot_pc", pc, 32'h0);
        check("boot_req", {31'd0, imem_req}, 32'd1);
        tick();
        check("seq_pc4", pc, 32'h4);
        tick();
        check("seq_pc8", pc, 32'h8);
        check("seq_flush", {31'd0, flush}, 32'd0);

        // Backward branch: 0x104 + (-2 << 2) = 0xFC.
        goto_addr(32'h100, "go100");
        pcsrc = 1'b1;
        instr = 26'h000_FFFE;
        tick();
        pcsrc = 1'b0;
        instr = '0;
        check("br_pc", pc, 32'h0000_00FC);
        check("br_flush", {31'd0, flush}, 32'd1);
        tick();
        check("br_after_pc", pc, 32'h0000_0100);
        check("br_after_flush", {31'd0, flush}, 32'd0);

        // Jump beats a simultaneous branch (branch would give 0x0040_0014).
        goto_addr(32'h0040_0010, "go400010");
        jump  = 1'b1;
        pcsrc = 1'b1;
        instr = 26'h010_0000;
        tick();
        jump  = 1'b0;
        pcsrc = 1'b0;
        instr = '0;
        check("jmp_pc", pc, 32'h0040_0000);
        check("jmp_flush", {31'd0, flush}, 32'd1);

        // Jump deferred through three not-ready cycles; a lower-priority branch in HOLD is dropped.
        goto_addr(32'h20, "go20");
        imem_ready = 1'b0;
        jump       = 1'b1;
        instr      = 26'h000_0050;
        tick();
        jump  = 1'b0;
        instr = '0;
        check("hold1_pc", pc, 32'h20);
        check("hold1_flush", {31'd0, flush}, 32'd0);
        check("hold1_req", {31'd0, imem_req}, 32'd1);
        pcsrc = 1'b1;
        instr = 26'h000_0100;
        tick();
        pcsrc = 1'b0;
        instr = '0;
        check("hold2_pc", pc, 32'h20);
        tick();
        check("hold3_pc", pc, 32'h20);
        check("hold3_flush", {31'd0, flush}, 32'd0);
        imem_ready = 1'b1;
        tick();
        check("land_pc", pc, 32'h140);
        check("land_flush", {31'd0, flush}, 32'd1);
        tick();
        check("land_next_pc", pc, 32'h144);
        check("land_next_flush", {31'd0, flush}, 32'd0);

        // Stall holds pc with no flush.
        goto_addr(32'h30, "go30");
        stall = 1'b1;
        tick();
        check("stall1_pc", pc, 32'h30);
        check("stall1_flush", {31'd0, flush}, 32'd0);
        tick();
        check("stall2_pc", pc, 32'h30);
        stall = 1'b0;
        tick();
        check("unstall_pc", pc, 32'h34);

        // Reset while a redirect is pending drops it.
        imem_ready = 1'b0;
        jump       = 1'b1;
        instr      = 26'h000_0060;
        tick();
        jump  = 1'b0;
        instr = '0;
        check("prerst_pc", pc, 32'h34);
        reset = 1'b1;
        tick();
        check("midrst_pc", pc, 32'h0);
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_flush", {31'd0, flush}, 32'd0);
        reset      = 1'b0;
        imem_ready = 1'b1;
        tick();
        check("reboot_pc", pc, 32'h0);
        check("reboot_req", {31'd0, imem_req}, 32'd1);
        tick();
        check("reboot_next_pc", pc, 32'h4);
        check("reboot_flush", {31'd0, flush}, 32'd0);

        // Wrap: 0x8 + (-3 << 2) = 0xFFFF_FFFC, then +4 wraps to 0.
        pcsrc = 1'b1;
        instr = 26'h000_FFFD;
        tick();
        pcsrc = 1'b0;
        instr = '0;
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_zero_pc", pc, 32'h0);
        check("wrap_flush", {31'd0, flush}, 32'd0);

`ifdef PC_SEQ_EXC_EN
        // Exception during stall overrides a pending jump and clears it.
        goto_addr(32'h44, "go44");
        stall = 1'b1;
        jump  = 1'b1;
        instr = 26'h000_0200;
        tick();
        jump  = 1'b0;
        instr = '0;
        check("exc_hold_pc", pc, 32'h44);
        exc = 1'b1;
        tick();
        exc = 1'b0;
        check("exc_pc", pc, 32'h8000_0180);
        check("exc_epc", epc, 32'h44);
        check("exc_flush", {31'd0, flush}, 32'd1);
        stall = 1'b0;
        tick();
        check("exc_next_pc", pc, 32'h8000_0184);
        check("exc_next_flush", {31'd0, flush}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
